// File: rtl/b03_fifo_sched.sv
// First-come-first-served scheduler sharing one resource among 4 requesters.
// Pending requester IDs sit in an in-order queue; a hold-time watchdog
// forcibly revokes a grant that is never released.
module b03_fifo_sched #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout,
    output logic [2:0] q_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        state;
    logic [1:0]        owner;
    logic [HOLD_W-1:0] hold;

    logic [1:0] q [4];
    logic [3:0] pending;

    logic [1:0] q_nxt [4];
    logic [2:0] cnt_nxt;
    logic [3:0] pend_nxt;
    logic       pop;
    logic [3:0] head_oh;
    logic [3:0] owner_mask;
    logic [3:0] arrive;

    // Pop happens whenever the resource is free and someone is waiting;
    // the current owner is excluded from re-enqueueing while it holds grant.
    always_comb begin
        pop        = (state != GRANT) && (q_count != 3'd0);
        head_oh    = 4'b0001 << q[0];
        owner_mask = (state == GRANT) ? (4'b0001 << owner) : 4'b0000;
        arrive     = req & ~pending & ~owner_mask;
    end

    // Next queue contents: drop the head on pop, then append new arrivals
    // in index order behind the surviving entries.
    always_comb begin
        q_nxt   = q;
        cnt_nxt = q_count;
        if (pop) begin
            for (int k = 0; k < 3; k++) begin
                q_nxt[k] = q[k+1];
            end
            q_nxt[3] = 2'd0;
            cnt_nxt  = q_count - 3'd1;
        end
        // Each ID is queued at most once, so cnt_nxt never exceeds 3 here.
        for (int i = 0; i < 4; i++) begin
            if (arrive[i]) begin
                q_nxt[cnt_nxt[1:0]] = 2'(i);
                cnt_nxt             = cnt_nxt + 3'd1;
            end
        end
        pend_nxt = (pending | arrive) & ~(pop ? head_oh : 4'b0000);
    end

    // Queue storage, occupancy and per-requester pending flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                q[k] <= 2'd0;
            end
            q_count <= 3'd0;
            pending <= 4'b0000;
        end else begin
            q       <= q_nxt;
            q_count <= cnt_nxt;
            pending <= pend_nxt;
        end
    end

    // Grant sequencer: IDLE -> GRANT on pop, GRANT -> GAP on done or
    // watchdog expiry, GAP always lasts one cycle with grant low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= 2'd0;
            hold    <= '0;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pop) begin
                        state <= GRANT;
                        owner <= q[0];
                        grant <= head_oh;
                        hold  <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    hold <= hold + HOLD_W'(1);
                    // done outranks the watchdog when both land on one edge
                    if (done[owner]) begin
                        state <= GAP;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                    end else if (hold == HOLD_LAST) begin
                        state   <= GAP;
                        grant   <= 4'b0000;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b03_fifo_sched.sv
// Scoreboard bench for b03_fifo_sched: directed stimulus pushes the expected
// grant episodes; a negedge monitor pops and compares each episode.
module tb_b03_fifo_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;
    logic [2:0] q_count;

    b03_fifo_sched #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout),
        .q_count (q_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] g;
        int         len;  // 0 = episode cut by reset, length not checked
        bit         to;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [3:0] g, input int len, input bit to);
        exp_t e;
        e.g = g; e.len = len; e.to = to;
        expq.push_back(e);
    endtask

    task automatic wait_grant(input int id, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clock); #1;
            waited++;
            if (grant[id[1:0]]) got = 1'b1;
        end
        if (!got) chk($sformatf("grant_wait_%0d", id), 0, 1);
    endtask

    // Wait for id to be granted, drop its req, hold k cycles, pulse done.
    task automatic serve(input int id, input int k, input int exp_q, input int exp_wait);
        int w;
        wait_grant(id, w);
        chk($sformatf("gap_wait_%0d", id), w, exp_wait);
        chk($sformatf("q_count_at_grant_%0d", id), int'(q_count), exp_q);
        req[id[1:0]] = 1'b0;
        repeat (k - 1) begin
            @(posedge clock); #1;
        end
        done[id[1:0]] = 1'b1;
        @(posedge clock); #1;
        done = 4'b0000;
    endtask

    // Monitor: every grant episode must match the next scoreboard entry.
    logic [3:0] prev_g = 4'b0000;
    int         len    = 0;
    bit         active = 1'b0;
    exp_t       cur;

    always @(negedge clock) begin
        if (!reset) begin
            active = 1'b0;
            prev_g = 4'b0000;
        end else begin
            if (grant != 4'b0000 && prev_g == 4'b0000) begin
                if (expq.size() == 0) begin
                    chk("grant_unexpected", int'(grant), 0);
                end else begin
                    cur = expq.pop_front();
                    chk("grant_order", int'(grant), int'(cur.g));
                    active = 1'b1;
                    len    = 1;
                end
            end else if (grant != 4'b0000) begin
                if (grant != prev_g) chk("grant_stable", int'(grant), int'(prev_g));
                len++;
            end else if (prev_g != 4'b0000 && active) begin
                if (cur.len > 0) chk("hold_len", len, cur.len);
                chk("timeout_at_revoke", int'(timeout), int'(cur.to));
                active = 1'b0;
            end else if (timeout) begin
                chk("timeout_spurious", 1, 0);
            end
            prev_g = grant;
        end
    end

    initial begin
        int w;
        reset = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        #2;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_q_count", int'(q_count), 0);
        @(posedge clock); #3 reset = 1'b1;
        @(posedge clock); #1;

        // 1: single requester, enqueue then grant, release after 1 cycle
        expect_grant(4'b0001, 1, 1'b0);
        req = 4'b0001;
        @(posedge clock); #1;
        chk("t1_q_count", int'(q_count), 1);
        chk("t1_grant_pre", int'(grant), 0);
        @(posedge clock); #1;
        chk("t1_grant", int'(grant), 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_q_after_pop", int'(q_count), 0);
        req  = 4'b0000;
        done = 4'b0001;
        @(posedge clock); #1;
        done = 4'b0000;
        chk("t1_gap_grant", int'(grant), 0);
        chk("t1_gap_busy", int'(busy), 0);
        @(posedge clock); #1;
        chk("t1_idle_grant", int'(grant), 0);
        chk("t1_idle_q", int'(q_count), 0);

        // 2: all four at once, served in index order
        expect_grant(4'b0001, 2, 1'b0);
        expect_grant(4'b0010, 2, 1'b0);
        expect_grant(4'b0100, 2, 1'b0);
        expect_grant(4'b1000, 2, 1'b0);
        req = 4'b1111;
        @(posedge clock); #1;
        chk("t2_q_full", int'(q_count), 4);
        serve(0, 2, 3, 1);
        serve(1, 2, 2, 1);
        serve(2, 2, 1, 1);
        serve(3, 2, 0, 1);
        @(posedge clock); #1;

        // 3: arrivals 3,1,0 while 2 owns -> FIFO order, not priority
        expect_grant(4'b0100, 4, 1'b0);
        expect_grant(4'b1000, 2, 1'b0);
        expect_grant(4'b0010, 2, 1'b0);
        expect_grant(4'b0001, 2, 1'b0);
        req = 4'b0100;
        wait_grant(2, w);
        chk("t3_first_latency", w, 2);
        req[2] = 1'b0;
        req[3] = 1'b1;
        @(posedge clock); #1;
        req[1] = 1'b1;
        @(posedge clock); #1;
        req[0] = 1'b1;
        @(posedge clock); #1;
        chk("t3_q_count", int'(q_count), 3);
        done = 4'b0100;
        @(posedge clock); #1;
        done = 4'b0000;
        serve(3, 2, 2, 1);
        serve(1, 2, 1, 1);
        serve(0, 2, 0, 1);
        @(posedge clock); #1;

        // 4: owner never releases -> 15-cycle grant, timeout, next granted
        expect_grant(4'b0001, 15, 1'b1);
        expect_grant(4'b0010, 1, 1'b0);
        req = 4'b0011;
        wait_grant(0, w);
        chk("t4_latency", w, 2);
        chk("t4_q_count", int'(q_count), 1);
        req[0] = 1'b0;
        repeat (15) begin
            @(posedge clock); #1;
        end
        chk("t4_timeout", int'(timeout), 1);
        chk("t4_revoke_grant", int'(grant), 0);
        chk("t4_revoke_busy", int'(busy), 0);
        serve(1, 1, 0, 1);
        @(posedge clock); #1;

        // 5: non-owner done ignored; done on watchdog expiry edge wins
        expect_grant(4'b0001, 4, 1'b0);
        expect_grant(4'b0010, 15, 1'b0);
        req = 4'b0011;
        wait_grant(0, w);
        req[0] = 1'b0;
        @(posedge clock); #1;
        done = 4'b1110;
        @(posedge clock); #1;
        done = 4'b0000;
        chk("t5_nonowner_done", int'(grant), 1);
        chk("t5_nonowner_busy", int'(busy), 1);
        @(posedge clock); #1;
        done = 4'b0001;
        @(posedge clock); #1;
        done = 4'b0000;
        serve(1, 15, 0, 1);
        chk("t5_done_beats_watchdog", int'(timeout), 0);
        chk("t5_gap_grant", int'(grant), 0);
        @(posedge clock); #1;
        chk("t5_idle_timeout", int'(timeout), 0);

        // 6: asynchronous reset mid-grant with three queued
        expect_grant(4'b0001, 0, 1'b0);
        req = 4'b1111;
        wait_grant(0, w);
        chk("t6_q_count", int'(q_count), 3);
        #6 reset = 1'b0;
        #1;
        chk("t6_async_grant", int'(grant), 0);
        chk("t6_async_q", int'(q_count), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_timeout", int'(timeout), 0);
        req = 4'b0000;
        @(posedge clock);
        @(posedge clock); #3 reset = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        chk("t6_idle_grant", int'(grant), 0);
        chk("t6_idle_busy", int'(busy), 0);
        chk("t6_idle_q", int'(q_count), 0);

        chk("scoreboard_drain", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/b03_fifo_sched.md
Name: b03_fifo_sched

Overview:
- First-come-first-served scheduler that shares one resource between 4 requesters.
- Uses a request/grant/done handshake.
- Pending requester IDs are held in an in-order queue. A hold-time watchdog revokes a grant that is never released.
- Sits in front of the shared datapath, beside the b03 arbiter family. It is the sequencer that owns the grant lines.

Parameters:
- MAX_HOLD, 15: maximum number of cycles a grant is held before forced revoke (1..15).
- HOLD_W, 4: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  4  level request per requester, bit i = requester i.
- done  input  4  release strobe from requester i. Only the current owner's bit is honoured.
- grant  output  4  registered one-hot grant; all-zero when the resource is free.
- busy  output  1  high while a grant is active (state GRANT).
- timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.
- q_count  output  3  number of queued requesters, 0..4.

Behaviour:

Reset:
- Reset low clears the following immediately, without waiting for a clock edge: state=IDLE, queue empty, q_count=0, grant=0, busy=0, timeout=0, hold counter=0, all pending flags=0.
- Reset mid-grant drops grant asynchronously. No timeout pulse is generated.

Queue:
- 4 entries of 2-bit IDs, plus a pending flag per requester.
- Requester i is enqueued at a rising edge when all of the following hold:
  - req[i]=1
  - pending[i]=0
  - i is not the current owner
- Several new requests at the same edge are appended in index order 0,1,2,3.
- Each ID can appear at most once, so the queue cannot overflow. Full is q_count=4.
- Pop and append at the same edge are allowed. The pop removes the head; new IDs append after the surviving entries.
- pending[i] clears when i is popped.
- A queued entry stays until served, even if req drops. Requesters must hold req until granted.

FSM:
- IDLE:
  - grant=0.
  - If q_count>0 at the edge: pop the head, set grant to that ID's one-hot, clear the hold counter, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - busy=1. The hold counter increments every cycle.
  - If done[owner]=1: go to GAP.
  - Else if the hold counter == MAX_HOLD-1: go to GAP and pulse timeout in the following cycle. The grant therefore lasts exactly MAX_HOLD cycles.
  - done and watchdog expiry at the same edge: done wins, no timeout.
  - done bits from non-owners are ignored.
- GAP:
  - grant=0 for exactly one cycle; timeout is high here if the revoke was forced.
  - The former owner may be enqueued during GAP.
  - Next edge: pop and go to GRANT if q_count>0, else go to IDLE.

Latency:
- From IDLE with an empty queue: req sampled at edge t is enqueued at t; grant is high after edge t+1.
- Between consecutive owners there is always exactly one grant-low cycle.

Outputs:
- All outputs are registered.
- q_count reflects the queue after the most recent edge.

Test Plan:
1. Reset, then req=0001 held -> q_count=1 after the 1st edge; grant=0001 and busy=1 after the 2nd edge. done=0001 for one cycle -> grant=0000 for one cycle, then IDLE.
2. req=1111 at the same edge while idle -> grants follow the order 0001, 0010, 0100, 1000. Each is released by done after 2 cycles, with one zero cycle between grants. q_count goes 4→3→2→1→0.
3. Arrival order 3 then 1 then 0 on separate edges while requester 2 owns -> after requester 2 is done, grants are 1000, 0010, 0001 (FIFO order, not priority order).
4. Owner never asserts done with MAX_HOLD=15 -> grant is high for exactly 15 cycles, then timeout=1 for one cycle with grant=0. The next queued requester is granted on the following edge.
5. done[owner] asserted on the same cycle the watchdog expires -> no timeout pulse. Also: done from a non-owner mid-grant -> ignored, grant unchanged.
6. Reset driven low mid-grant with q_count=3 -> grant=0, q_count=0, busy=0 with no clock edge. After reset is released with req=0000 -> the block stays IDLE.
